// File: rtl/branch_predict_unit.sv
// ID-stage branch resolver with a saturating-counter branch history table.
// Drives the fetch PC-select and IF/ID flush, and keeps branch/mispredict statistics.
module branch_predict_unit #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 32,
   parameter int BHT_IDX_W = 6,
   parameter int CTR_W     = 2,
   parameter int STAT_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] if_pc,
   output logic              if_pred_taken,
   input  logic              id_valid,
   input  logic              id_stall,
   input  logic [ADDR_W-1:0] id_pc,
   input  logic [5:0]        op,
   input  logic [4:0]        rt,
   input  logic [DATA_W-1:0] data_1,
   input  logic [DATA_W-1:0] data_2,
   input  logic              if_jump,
   input  logic              id_pred_taken,
   output logic [1:0]        AddressSelect,
   output logic              IFID_flush,
   output logic [STAT_W-1:0] branch_count,
   output logic [STAT_W-1:0] mispredict_count
);

   localparam int ENTRIES = 1 << BHT_IDX_W;
   localparam logic [CTR_W-1:0] CTR_INIT = {1'b0, {(CTR_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] ZERO = '0;

   localparam logic [5:0] OP_REGIMM = 6'b000001;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_BNE    = 6'b000101;
   localparam logic [5:0] OP_BLEZ   = 6'b000110;
   localparam logic [5:0] OP_BGTZ   = 6'b000111;

   localparam logic [1:0] SEL_SEQ    = 2'b00;
   localparam logic [1:0] SEL_BRANCH = 2'b01;
   localparam logic [1:0] SEL_JUMP   = 2'b10;
   localparam logic [1:0] SEL_RECOV  = 2'b11;

   function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] c);
      return (&c) ? c : c + CTR_W'(1);
   endfunction

   function automatic logic [CTR_W-1:0] sat_dec(input logic [CTR_W-1:0] c);
      return (c == '0) ? c : c - CTR_W'(1);
   endfunction

   logic [CTR_W-1:0]     bht [ENTRIES];
   logic [BHT_IDX_W-1:0] if_idx;
   logic [BHT_IDX_W-1:0] id_idx;
   logic signed [DATA_W-1:0] rs_s;
   logic                 act;
   logic                 is_branch;
   logic                 taken;
   logic                 upd;

   assign if_idx = if_pc[BHT_IDX_W+1:2];
   assign id_idx = id_pc[BHT_IDX_W+1:2];
   assign rs_s   = data_1;
   assign act    = id_valid && !id_stall;

   // Read happens before any same-cycle write lands, so IF sees the old counter.
   assign if_pred_taken = bht[if_idx][CTR_W-1];

   always_comb begin
      is_branch = 1'b0;
      taken     = 1'b0;
      case (op)
         OP_BEQ:  begin is_branch = 1'b1; taken = (data_1 == data_2); end
         OP_BNE:  begin is_branch = 1'b1; taken = (data_1 != data_2); end
         OP_BLEZ: begin is_branch = 1'b1; taken = (rs_s <= ZERO);     end
         OP_BGTZ: begin is_branch = 1'b1; taken = (rs_s >  ZERO);     end
         OP_REGIMM: begin
            if (rt == 5'b00000) begin
               is_branch = 1'b1;
               taken     = (rs_s < ZERO);
            end else if (rt == 5'b00001) begin
               is_branch = 1'b1;
               taken     = (rs_s >= ZERO);
            end
         end
         default: ;
      endcase
   end

   // A jump wins over any branch decode and leaves predictor state untouched.
   assign upd = act && is_branch && !if_jump;

   always_comb begin
      AddressSelect = SEL_SEQ;
      IFID_flush    = 1'b0;
      if (rst_n && act) begin
         if (if_jump) begin
            AddressSelect = SEL_JUMP;
            IFID_flush    = 1'b1;
         end else if (is_branch) begin
            if (taken && !id_pred_taken) begin
               AddressSelect = SEL_BRANCH;
               IFID_flush    = 1'b1;
            end else if (!taken && id_pred_taken) begin
               AddressSelect = SEL_RECOV;
               IFID_flush    = 1'b1;
            end
         end else if (id_pred_taken) begin
            AddressSelect = SEL_RECOV;
            IFID_flush    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) bht[i] <= CTR_INIT;
      end else if (upd) begin
         bht[id_idx] <= taken ? sat_inc(bht[id_idx]) : sat_dec(bht[id_idx]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_count     <= '0;
         mispredict_count <= '0;
      end else if (upd) begin
         branch_count <= branch_count + STAT_W'(1);
         if (taken != id_pred_taken) mispredict_count <= mispredict_count + STAT_W'(1);
      end
   end

   logic unused_pc_bits;
   assign unused_pc_bits = ^{if_pc[ADDR_W-1:BHT_IDX_W+2], if_pc[1:0],
                             id_pc[ADDR_W-1:BHT_IDX_W+2], id_pc[1:0]};

endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: directed steps then random traffic, checked
// against an array-based model of the predictor table and statistics.
module tb_branch_predict_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] if_pc = 32'h0040_0000;
   logic        if_pred_taken;
   logic        id_valid = 1'b0;
   logic        id_stall = 1'b0;
   logic [31:0] id_pc = '0;
   logic [5:0]  op = '0;
   logic [4:0]  rt = '0;
   logic [31:0] data_1 = '0;
   logic [31:0] data_2 = '0;
   logic        if_jump = 1'b0;
   logic        id_pred_taken = 1'b0;
   logic [1:0]  AddressSelect;
   logic        IFID_flush;
   logic [3:0]  branch_count;
   logic [3:0]  mispredict_count;

   int checks = 0;
   int errors = 0;

   int bht_m [64];
   int bc_m;
   int mc_m;

   branch_predict_unit #(.DATA_W(32), .ADDR_W(32), .BHT_IDX_W(6), .CTR_W(2), .STAT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
      .id_valid(id_valid), .id_stall(id_stall), .id_pc(id_pc), .op(op), .rt(rt),
      .data_1(data_1), .data_2(data_2), .if_jump(if_jump), .id_pred_taken(id_pred_taken),
      .AddressSelect(AddressSelect), .IFID_flush(IFID_flush),
      .branch_count(branch_count), .mispredict_count(mispredict_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 64; i++) bht_m[i] = 1;
      bc_m = 0;
      mc_m = 0;
   endtask

   // Branch semantics from the opcode table, using signed int arithmetic.
   task automatic decode(input logic [5:0] o, input logic [4:0] r, input int a, input int b,
                         output bit br, output bit tk);
      br = 1'b0; tk = 1'b0;
      case (o)
         6'd4: begin br = 1; tk = (a == b); end
         6'd5: begin br = 1; tk = (a != b); end
         6'd6: begin br = 1; tk = (a <= 0); end
         6'd7: begin br = 1; tk = (a > 0);  end
         6'd1: if (r == 0) begin br = 1; tk = (a < 0); end
               else if (r == 1) begin br = 1; tk = (a >= 0); end
         default: ;
      endcase
   endtask

   function automatic int pidx(input logic [31:0] pc);
      return int'(pc[7:2]);
   endfunction

   // One ID cycle; called #1 after a rising edge, returns #1 after the next one.
   task automatic cycle(input string tag, input bit v, input bit st, input bit jmp,
                        input logic [5:0] o, input logic [4:0] r, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] pc, input bit pred,
                        input logic [31:0] ipc);
      bit br, tk, act;
      int exp_sel;
      bit exp_fl;
      id_valid = v; id_stall = st; if_jump = jmp; op = o; rt = r;
      data_1 = a; data_2 = b; id_pc = pc; id_pred_taken = pred; if_pc = ipc;
      decode(o, r, int'(a), int'(b), br, tk);
      act = v && !st;
      exp_sel = 0; exp_fl = 0;
      if (act) begin
         if (jmp) begin exp_sel = 2; exp_fl = 1; end
         else if (br && tk != pred) begin exp_sel = tk ? 1 : 3; exp_fl = 1; end
         else if (!br && pred) begin exp_sel = 3; exp_fl = 1; end
      end
      #1;
      chk({tag, ".sel"}, 32'(AddressSelect), 32'(exp_sel));
      chk({tag, ".flush"}, 32'(IFID_flush), 32'(exp_fl));
      chk({tag, ".pred_pre"}, 32'(if_pred_taken), 32'(bht_m[pidx(ipc)] >= 2));
      @(posedge clk);
      if (act && br && !jmp) begin
         bht_m[pidx(pc)] = tk ? (bht_m[pidx(pc)] == 3 ? 3 : bht_m[pidx(pc)] + 1)
                              : (bht_m[pidx(pc)] == 0 ? 0 : bht_m[pidx(pc)] - 1);
         bc_m++;
         if (tk != pred) mc_m++;
      end
      #1;
      chk({tag, ".pred_post"}, 32'(if_pred_taken), 32'(bht_m[pidx(ipc)] >= 2));
      chk({tag, ".bcnt"}, 32'(branch_count), 32'(bc_m % 16));
      chk({tag, ".mcnt"}, 32'(mispredict_count), 32'(mc_m % 16));
   endtask

   initial begin
      logic [5:0]  ops [7];
      logic [31:0] vals [6];
      logic [31:0] rpc;
      ops  = '{6'd4, 6'd5, 6'd6, 6'd7, 6'd1, 6'd35, 6'd0};
      vals = '{32'h0, 32'h5, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1};
      model_reset();

      // Reset: outputs forced quiet even with a jump presented.
      id_valid = 1; if_jump = 1;
      #1;
      chk("rst.pred", 32'(if_pred_taken), 32'd0);
      chk("rst.sel", 32'(AddressSelect), 32'd0);
      chk("rst.flush", 32'(IFID_flush), 32'd0);
      id_valid = 0; if_jump = 0;
      #12 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rel.sel", 32'(AddressSelect), 32'd0);
      chk("rel.flush", 32'(IFID_flush), 32'd0);
      chk("rel.bcnt", 32'(branch_count), 32'd0);
      chk("rel.mcnt", 32'(mispredict_count), 32'd0);

      // Train a beq at 0x10 up to saturation, then mispredict not-taken.
      cycle("beq1", 1, 0, 0, 6'd4, 5'd0, 32'd5, 32'd5, 32'h10, 0, 32'h10);
      cycle("beq2", 1, 0, 0, 6'd4, 5'd0, 32'd5, 32'd5, 32'h10, 1, 32'h10);
      cycle("beq3", 1, 0, 0, 6'd4, 5'd0, 32'd5, 32'd5, 32'h10, 1, 32'h10);
      cycle("beq4", 1, 0, 0, 6'd4, 5'd0, 32'd5, 32'd5, 32'h10, 1, 32'h10);
      cycle("beq_nt", 1, 0, 0, 6'd4, 5'd0, 32'd5, 32'd6, 32'h10, 1, 32'h10);

      // Signed comparisons.
      cycle("bgtz_neg", 1, 0, 0, 6'd7, 5'd0, 32'h8000_0000, 32'd0, 32'h20, 0, 32'h20);
      cycle("bltz_neg", 1, 0, 0, 6'd1, 5'd0, 32'h8000_0000, 32'd0, 32'h24, 0, 32'h24);
      cycle("bgez_0", 1, 0, 0, 6'd1, 5'd1, 32'd0, 32'd0, 32'h28, 0, 32'h28);
      cycle("blez_0", 1, 0, 0, 6'd6, 5'd0, 32'd0, 32'd0, 32'h2C, 1, 32'h2C);
      cycle("regimm_x", 1, 0, 0, 6'd1, 5'd2, 32'd0, 32'd0, 32'h30, 0, 32'h30);

      // Jump priority over a mispredicted taken bne.
      cycle("jmp_bne", 1, 0, 1, 6'd5, 5'd0, 32'd1, 32'd2, 32'h34, 0, 32'h34);

      // Stalled taken beq resolves once, when the stall drops.
      cycle("stall1", 1, 1, 0, 6'd4, 5'd0, 32'd7, 32'd7, 32'h38, 0, 32'h38);
      cycle("stall2", 1, 1, 0, 6'd4, 5'd0, 32'd7, 32'd7, 32'h38, 0, 32'h38);
      cycle("unstall", 1, 0, 0, 6'd4, 5'd0, 32'd7, 32'd7, 32'h38, 0, 32'h38);

      // Aliased prediction on a load.
      cycle("alias_lw", 1, 0, 0, 6'd35, 5'd0, 32'd0, 32'd0, 32'h3C, 1, 32'h3C);
      cycle("invalid", 0, 0, 1, 6'd4, 5'd0, 32'd0, 32'd0, 32'h40, 0, 32'h40);

      // Enough branches to wrap the 4-bit statistics counters.
      for (int i = 0; i < 17; i++)
         cycle("wrap", 1, 0, 0, 6'd5, 5'd0, 32'(i), 32'd3, 32'h80 + 32'(4 * (i % 4)), i[0], 32'h84);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         rpc = {24'h0, 6'($urandom_range(0, 7)), 2'b00};
         cycle("rand", $urandom_range(0, 9) != 0, $urandom_range(0, 5) == 0,
               $urandom_range(0, 9) == 0, ops[$urandom_range(0, 6)],
               5'($urandom_range(0, 3)), vals[$urandom_range(0, 5)],
               vals[$urandom_range(0, 5)], rpc, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 1) != 0) ? rpc : {24'h0, 6'($urandom_range(0, 7)), 2'b00});
      end

      // Reset asserted mid-cycle with a branch in flight.
      id_valid = 1; id_stall = 0; if_jump = 0; op = 6'd4; data_1 = 1; data_2 = 1;
      id_pc = 32'h10; id_pred_taken = 0; if_pc = 32'h10;
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      chk("mid.sel", 32'(AddressSelect), 32'd0);
      chk("mid.flush", 32'(IFID_flush), 32'd0);
      chk("mid.pred", 32'(if_pred_taken), 32'd0);
      chk("mid.bcnt", 32'(branch_count), 32'd0);
      @(posedge clk); #1;
      chk("mid.bcnt2", 32'(branch_count), 32'd0);
      chk("mid.mcnt", 32'(mispredict_count), 32'd0);
      id_valid = 0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      cycle("post_rst", 1, 0, 0, 6'd4, 5'd0, 32'd1, 32'd1, 32'h10, 0, 32'h10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- ID-stage branch resolution unit for the 5-stage MIPS pipeline, with a parametrised branch history table (BHT) of saturating counters.
- IF uses the BHT prediction to choose its next fetch address.
- ID resolves beq/bne/blez/bgtz/bltz/bgez and jumps, drives the PC-select mux and the IF/ID flush, and trains the BHT.
- Keeps branch and mispredict statistics counters for performance measurement.

Parameters:
- DATA_W, 32, operand width for the comparisons (signed two's complement).
- ADDR_W, 32, PC width.
- BHT_IDX_W, 6, log2 of the BHT entry count (64 entries); index = pc[BHT_IDX_W+1:2].
- CTR_W, 2, width of each saturating counter (≥2).
- STAT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_pc  in  ADDR_W  PC being fetched
- if_pred_taken  out  1  prediction for if_pc (MSB of the BHT entry)
- id_valid  in  1  the IF/ID register holds a real instruction
- id_stall  in  1  ID is held by the hazard unit this cycle
- id_pc  in  ADDR_W  PC of the instruction in ID
- op  in  6  opcode of the instruction in ID
- rt  in  5  rt field; selects bltz/bgez under REGIMM
- data_1  in  DATA_W  forwarded rs value
- data_2  in  DATA_W  forwarded rt value
- if_jump  in  1  the instruction in ID is j/jal/jr
- id_pred_taken  in  1  prediction made in IF, carried in IF/ID
- AddressSelect  out  2  00 sequential, 01 branch target, 10 jump target, 11 recovery to id_pc+4
- IFID_flush  out  1  squash the IF/ID register
- branch_count  out  STAT_W  resolved conditional branches
- mispredict_count  out  STAT_W  mispredicted conditional branches

Behaviour:
- Reset (rst_n low, async):
  - every BHT entry = 2^(CTR_W-1)-1 (01 for CTR_W=2, weakly not-taken);
  - branch_count = mispredict_count = 0;
  - AddressSelect forced 00 and IFID_flush forced 0 while rst_n is low.
- Branch decode:
  - beq 000100: data_1 == data_2
  - bne 000101: data_1 != data_2
  - blez 000110: data_1 ≤ 0 (signed)
  - bgtz 000111: data_1 > 0 (signed)
  - REGIMM 000001 with rt=00000 bltz: data_1 < 0; with rt=00001 bgez: data_1 ≥ 0
  - any other rt under REGIMM is not a branch.
- act = id_valid && !id_stall. When act = 0, outputs are 00/0 and no state changes. A stalled branch resolves in the first unstalled cycle.
- Combinational resolve when act = 1, in priority order:
  - if_jump → AddressSelect 10, flush 1 (takes priority over everything).
  - branch, taken, id_pred_taken = 0 → 01, flush 1.
  - branch, not taken, id_pred_taken = 1 → 11, flush 1.
  - branch, outcome matches prediction → 00, flush 0 (IF already on the correct path).
  - non-branch, non-jump with id_pred_taken = 1 (BHT alias) → 11, flush 1. No BHT update, no stats update.
  - otherwise → 00, flush 0.
- Sequential update on posedge clk, when act is high and the instruction is a branch:
  - BHT[id_pc idx] += 1 if taken, saturating at all-ones; -= 1 if not taken, saturating at 0;
  - branch_count += 1;
  - mispredict_count += 1 if taken != id_pred_taken;
  - both stats counters wrap modulo 2^STAT_W.
- Jumps do not touch the BHT or the stats counters.
- if_pred_taken is a combinational read of BHT[if_pc idx]. When IF reads the entry being written in the same cycle, it sees the pre-update value (no bypass).
- Latency: the redirect is same-cycle combinational. A BHT update becomes visible to if_pred_taken the cycle after the edge.
- Reset asserted mid-operation: the table and stats clear immediately; the in-flight branch is not recorded.

Test Plan:
- Reset, then if_pc=0x0040_0000 → if_pred_taken=0. Release reset with id_valid=0 → AddressSelect=00, IFID_flush=0, both counts 0.
- beq, data_1=data_2=5, id_pred_taken=0, id_pc=0x10 → 01/flush 1. Next cycle if_pc=0x10 → if_pred_taken=1. branch_count=1, mispredict_count=1.
- Same beq resolved taken 3 more times → counter saturates at 11. Then one not-taken with id_pred_taken=1 → 11/flush 1, counter 10, if_pred_taken still 1.
- bgtz, data_1=0x8000_0000 → not taken (signed). bltz (op 000001, rt 0), same data → taken. bgez, data_1=0 → taken.
- Simultaneous if_jump=1 and bne taken with a mismatched prediction → AddressSelect=10, flush 1, no BHT/stats change. id_stall=1 on a taken beq → 00/0 until the stall drops, then 01/1 with exactly one update.
- Non-branch op 100011 with id_pred_taken=1 → 11/flush 1, counts unchanged. Drive STAT_W=4 with 17 branches → branch_count wraps to 1.
